// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants, size helper and write-burst state enum
package axi_pkg;

    localparam logic [1:0] INCR   = 2'b01;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wburst_state_t;

    // AxSIZE encoding is log2 of the bytes per beat (1..128 bytes)
    function automatic logic [2:0] axsize(input int bytes);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bytes == (1 << i)) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wburst_len.sv
// rtl/wburst_len.sv - burst length and launch decision for the FIFO-to-AXI write drain
module wburst_len #(
    parameter int DW         = 32,
    parameter int LGFLEN     = 4,
    parameter int LGMAXBURST = 4
) (
    input  logic [11:0]     addr_lo,
    input  logic [LGFLEN:0] fill,
    input  logic            timeout_expired,
    output logic [8:0]      len,
    output logic            launch
);

    localparam int          LGBYTES = $clog2(DW / 8);
    localparam logic [12:0] MAXB    = 13'(1 << LGMAXBURST);

    logic [12:0] fill13;
    logic [12:0] b4k;
    logic [12:0] len13;

    assign fill13 = 13'(fill);

    // beats left before the 4 KB page ends, then the smallest of fill, max burst and that
    always_comb begin
        b4k   = (13'h1000 - {1'b0, addr_lo}) >> LGBYTES;
        len13 = fill13;
        if (MAXB < len13) begin
            len13 = MAXB;
        end
        if (b4k < len13) begin
            len13 = b4k;
        end
        len    = 9'(len13);
        launch = (fill13 >= MAXB)
               || ((fill13 >= b4k) && (fill13 != 13'd0))
               || (timeout_expired && (fill13 != 13'd0));
    end

endmodule

// File: rtl/fifo_axi_wburst.sv
// rtl/fifo_axi_wburst.sv - drains an FWFT FIFO into memory as AXI4 INCR write bursts
module fifo_axi_wburst
    import axi_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LGFLEN     = 4,
    parameter int LGMAXBURST = 4,
    parameter int LGTIMEOUT  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DW-1:0]     i_fifo_data,
    input  logic              i_fifo_empty,
    input  logic [LGFLEN:0]   i_fifo_fill,
    output logic              o_fifo_rd,
    input  logic [AW-1:0]     i_base,
    input  logic              i_restart,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [AW-1:0]     o_awaddr,
    output logic [7:0]        o_awlen,
    output logic [2:0]        o_awsize,
    output logic [1:0]        o_awburst,
    output logic              o_wvalid,
    input  logic              i_wready,
    output logic [DW-1:0]     o_wdata,
    output logic [DW/8-1:0]   o_wstrb,
    output logic              o_wlast,
    input  logic              i_bvalid,
    output logic              o_bready,
    input  logic [1:0]        i_bresp,
    output logic [AW-1:0]     o_addr,
    output logic              o_busy,
    output logic              o_err
);

    localparam int BYTES   = DW / 8;
    localparam int LGBYTES = $clog2(BYTES);

    wburst_state_t         state;
    wburst_state_t         state_next;
    logic [8:0]            beats;
    logic [8:0]            beat_cnt;
    logic [LGTIMEOUT-1:0]  timeout;
    logic                  timeout_expired;
    logic [8:0]            len;
    logic                  launch_ok;
    logic                  launch;
    logic [AW-1:0]         addr_step;
    logic                  unused_ok;

    // the FIFO fill count already says everything the empty flag would
    assign unused_ok = &{1'b0, i_fifo_empty};

    assign timeout_expired = &timeout;
    assign addr_step       = AW'(beats) << LGBYTES;

    assign o_awaddr  = o_addr;
    assign o_awsize  = axsize(BYTES);
    assign o_awburst = INCR;
    assign o_wdata   = i_fifo_data;
    assign o_wstrb   = {BYTES{1'b1}};

    wburst_len #(
        .DW         (DW),
        .LGFLEN     (LGFLEN),
        .LGMAXBURST (LGMAXBURST)
    ) u_len (
        .addr_lo         (o_addr[11:0]),
        .fill            (i_fifo_fill),
        .timeout_expired (timeout_expired),
        .len             (len),
        .launch          (launch_ok)
    );

    // state register; reset abandons any in-flight transaction
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and channel strobes; a restart in IDLE suppresses that cycle's launch
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        o_awvalid  = 1'b0;
        o_wvalid   = 1'b0;
        o_wlast    = 1'b0;
        o_bready   = 1'b0;
        o_fifo_rd  = 1'b0;
        o_busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (launch_ok && !i_restart) begin
                    launch     = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                o_awvalid = 1'b1;
                if (i_awready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                o_wvalid  = 1'b1;
                o_fifo_rd = i_wready;
                o_wlast   = (beat_cnt == 9'd1);
                if (i_wready && (beat_cnt == 9'd1)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                o_bready = 1'b1;
                if (i_bvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // address counter, burst length latch, beat countdown, idle timeout and sticky error
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_addr   <= '0;
            beats    <= '0;
            beat_cnt <= '0;
            o_awlen  <= '0;
            timeout  <= '0;
            o_err    <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && i_restart) begin
                o_addr <= i_base;
            end else if ((state == ST_ADDR) && i_awready) begin
                o_addr <= o_addr + addr_step;
            end

            if (launch) begin
                beats    <= len;
                beat_cnt <= len;
                o_awlen  <= 8'(len - 9'd1);
            end else if ((state == ST_DATA) && i_wready) begin
                beat_cnt <= beat_cnt - 9'd1;
            end

            if ((state != ST_IDLE) || (i_fifo_fill == '0) || launch) begin
                timeout <= '0;
            end else if (!timeout_expired) begin
                timeout <= timeout + 1'b1;
            end

            if ((state == ST_RESP) && i_bvalid && (i_bresp != OKAY)) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_axi_wburst.sv
// tb/tb_fifo_axi_wburst.sv - scoreboard bench for fifo_axi_wburst
module tb_fifo_axi_wburst;
    import axi_pkg::*;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int LGFLEN = 4;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [DW-1:0]     i_fifo_data;
    logic              i_fifo_empty;
    logic [LGFLEN:0]   i_fifo_fill;
    logic              o_fifo_rd;
    logic [AW-1:0]     i_base;
    logic              i_restart;
    logic              o_awvalid;
    logic              i_awready;
    logic [AW-1:0]     o_awaddr;
    logic [7:0]        o_awlen;
    logic [2:0]        o_awsize;
    logic [1:0]        o_awburst;
    logic              o_wvalid;
    logic              i_wready;
    logic [DW-1:0]     o_wdata;
    logic [DW/8-1:0]   o_wstrb;
    logic              o_wlast;
    logic              i_bvalid;
    logic              o_bready;
    logic [1:0]        i_bresp;
    logic [AW-1:0]     o_addr;
    logic              o_busy;
    logic              o_err;

    always #5 clk = ~clk;

    fifo_axi_wburst dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_fill  (i_fifo_fill),
        .o_fifo_rd    (o_fifo_rd),
        .i_base       (i_base),
        .i_restart    (i_restart),
        .o_awvalid    (o_awvalid),
        .i_awready    (i_awready),
        .o_awaddr     (o_awaddr),
        .o_awlen      (o_awlen),
        .o_awsize     (o_awsize),
        .o_awburst    (o_awburst),
        .o_wvalid     (o_wvalid),
        .i_wready     (i_wready),
        .o_wdata      (o_wdata),
        .o_wstrb      (o_wstrb),
        .o_wlast      (o_wlast),
        .i_bvalid     (i_bvalid),
        .o_bready     (o_bready),
        .i_bresp      (i_bresp),
        .o_addr       (o_addr),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    int              checks = 0;
    int              errors = 0;
    logic [DW-1:0]   fifo_q[$];
    logic [DW-1:0]   exp_w[$];
    logic [39:0]     exp_aw[$];
    bit              bp_mode = 1'b0;
    int              aw_stall = 0;
    logic [1:0]      bresp_val = OKAY;
    bit              pop_now = 1'b0;
    int              pops = 0;
    int              whs = 0;
    int              bcount = 0;
    int              cur_len = 0;
    int              beat = 0;
    bit              aw_held = 1'b0;
    logic [AW-1:0]   held_addr = '0;
    logic [7:0]      held_len = '0;
    int              data_seq = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic update_fifo_outs();
        i_fifo_fill  = 5'(fifo_q.size());
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DW'(data_seq));
            exp_w.push_back(DW'(data_seq));
            data_seq++;
        end
        update_fifo_outs();
    endtask

    task automatic push_aw(input logic [31:0] addr, input logic [7:0] len);
        exp_aw.push_back({addr, len});
    endtask

    task automatic monitor();
        logic [39:0] e;
        pop_now = 1'b0;
        if (o_awvalid) begin
            if (aw_held) begin
                check("aw_addr_stable", o_awaddr, held_addr);
                check("aw_len_stable", o_awlen, held_len);
            end
            if (i_awready) begin
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected", 1, 0);
                end else begin
                    e = exp_aw.pop_front();
                    check("awaddr", o_awaddr, e[39:8]);
                    check("awlen", o_awlen, e[7:0]);
                    check("awsize", o_awsize, 3'd2);
                    check("awburst", o_awburst, INCR);
                    cur_len = int'(e[7:0]);
                    beat = 0;
                end
                aw_held = 1'b0;
            end else begin
                aw_held   = 1'b1;
                held_addr = o_awaddr;
                held_len  = o_awlen;
            end
        end
        if (o_wvalid && i_wready) begin
            whs++;
            if (exp_w.size() == 0) begin
                check("w_unexpected", 1, 0);
            end else begin
                check("wdata", o_wdata, exp_w.pop_front());
            end
            check("wlast", o_wlast, (beat == cur_len));
            check("wstrb", o_wstrb, 4'hF);
            beat++;
        end
        if (o_fifo_rd) begin
            pops++;
            pop_now = 1'b1;
        end
        if (o_bready && i_bvalid) begin
            bcount++;
        end
    endtask

    task automatic drive_ready();
        if (bp_mode) begin
            aw_stall  = o_awvalid ? aw_stall + 1 : 0;
            i_awready = (aw_stall > 5);
            i_wready  = !i_wready;
        end else begin
            aw_stall  = 0;
            i_awready = 1'b1;
            i_wready  = 1'b1;
        end
        i_bvalid = o_bready;
        i_bresp  = bresp_val;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (pop_now && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
        end
        drive_ready();
        update_fifo_outs();
    endtask

    task automatic wait_bursts(input int n);
        int target;
        int k;
        target = bcount + n;
        k = 0;
        while (bcount < target && k < 3000) begin
            step();
            k++;
        end
        check("burst_done", bcount, target);
    endtask

    task automatic wait_wvalid();
        int k;
        k = 0;
        while (!o_wvalid && k < 200) begin
            step();
            k++;
        end
        check("wvalid_seen", o_wvalid, 1);
    endtask

    initial begin
        int n;
        int pops0;
        int whs0;

        i_reset   = 1'b1;
        i_base    = '0;
        i_restart = 1'b0;
        i_awready = 1'b1;
        i_wready  = 1'b1;
        i_bvalid  = 1'b0;
        i_bresp   = OKAY;
        update_fifo_outs();
        repeat (3) step();
        i_reset = 1'b0;
        step();

        check("rst_awvalid", o_awvalid, 0);
        check("rst_wvalid", o_wvalid, 0);
        check("rst_wlast", o_wlast, 0);
        check("rst_bready", o_bready, 0);
        check("rst_fifo_rd", o_fifo_rd, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        check("rst_addr", o_addr, 0);
        check("rst_awlen", o_awlen, 0);

        // full burst
        i_base    = 32'h1000;
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        check("restart_addr", o_addr, 32'h1000);
        pops0 = pops;
        push_aw(32'h1000, 8'd15);
        push_words(16);
        wait_bursts(1);
        check("full_addr", o_addr, 32'h1040);
        check("full_pops", pops - pops0, 16);

        // 4 KB boundary
        i_base    = 32'h1FF8;
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        push_aw(32'h1FF8, 8'd1);
        push_words(16);
        wait_bursts(1);
        check("b4k_addr_first", o_addr, 32'h2000);
        push_aw(32'h2000, 8'd15);
        push_words(2);
        wait_bursts(1);
        check("b4k_addr_second", o_addr, 32'h2040);

        // timeout flush
        push_aw(32'h2040, 8'd2);
        push_words(3);
        n = 0;
        while (!o_awvalid && n < 600) begin
            step();
            n++;
        end
        check("timeout_lat", n, 256);
        wait_bursts(1);
        check("timeout_addr", o_addr, 32'h204C);

        // backpressure
        bp_mode = 1'b1;
        pops0   = pops;
        whs0    = whs;
        push_aw(32'h204C, 8'd15);
        push_words(16);
        wait_bursts(1);
        bp_mode = 1'b0;
        check("bp_pops_eq_whs", pops - pops0, whs - whs0);
        check("bp_whs", whs - whs0, 16);
        check("bp_addr", o_addr, 32'h208C);

        // error response stays sticky
        bresp_val = SLVERR;
        push_aw(32'h208C, 8'd15);
        push_words(16);
        wait_bursts(1);
        check("err_set", o_err, 1);
        bresp_val = OKAY;
        push_aw(32'h20CC, 8'd15);
        push_words(16);
        wait_bursts(1);
        check("err_sticky", o_err, 1);

        // restart during DATA is ignored
        push_aw(32'h210C, 8'd15);
        push_words(16);
        wait_wvalid();
        i_base    = 32'h5000;
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        check("restart_data_addr", o_addr, 32'h214C);
        wait_bursts(1);
        check("restart_final_addr", o_addr, 32'h214C);

        // reset mid-DATA
        push_aw(32'h214C, 8'd15);
        push_words(16);
        wait_wvalid();
        repeat (3) step();
        i_reset = 1'b1;
        step();
        check("mid_awvalid", o_awvalid, 0);
        check("mid_wvalid", o_wvalid, 0);
        check("mid_wlast", o_wlast, 0);
        check("mid_bready", o_bready, 0);
        check("mid_fifo_rd", o_fifo_rd, 0);
        check("mid_busy", o_busy, 0);
        check("mid_err", o_err, 0);
        check("mid_addr", o_addr, 0);
        check("mid_awlen", o_awlen, 0);
        i_reset = 1'b0;
        fifo_q.delete();
        exp_w.delete();
        update_fifo_outs();
        step();

        // recovery after reset
        push_aw(32'h0, 8'd15);
        push_words(16);
        wait_bursts(1);
        check("recover_addr", o_addr, 32'h40);
        check("recover_err", o_err, 0);
        check("aw_queue_empty", exp_aw.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
